// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue slice.
// Entry widths track the fetch_queue parameter defaults.
package fetch_pkg;

    localparam int FETCH_AW    = 32;
    localparam int FETCH_DW    = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [FETCH_DW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush.
// Pointers carry one extra bit so full and empty differ.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [PW:0]  count,
    output fetch_entry_t head
);

    fetch_entry_t mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[PW-1:0]] <= din;
    end

    // An empty queue presents zeros rather than stale storage.
    assign head = (count != '0) ? mem[rd_ptr[PW-1:0]] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC owner, imem request channel and decode-side queue.
// Define FETCH_PERF_EN to add flush/drop/stall counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr,
    input  logic                  out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_drop_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e          state;
    fetch_state_e          state_nx;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc_nx;
    logic [CW-1:0]         fifo_count;
    fetch_entry_t          din;
    fetch_entry_t          head;
    logic                  inflight;
    logic                  credit;
    logic                  room;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign inflight = (state == WAIT) || (state == DROP);
    assign accept   = imem_req_valid && imem_req_ready;
    assign push     = (state == WAIT) && imem_resp_valid && !redirect_valid;
    assign pop      = out_valid && out_ready && !redirect_valid;

    // Credit counts the outstanding word so a response always has a slot.
    assign credit = (fifo_count + CW'(inflight)) < CW'(DEPTH);
    assign room   = (fifo_count + CW'(1)) < (CW'(DEPTH) + CW'(pop));

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        unique case (state)
            IDLE: if (credit) state_nx = REQ;
            REQ: begin
                if (accept) begin
                    state_nx    = WAIT;
                    fetch_pc_nx = fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
                end
            end
            WAIT: if (imem_resp_valid) state_nx = room ? REQ : IDLE;
            DROP: if (imem_resp_valid) state_nx = REQ;
            default: state_nx = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_nx = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            unique case (1'b1)
                state == IDLE: state_nx = REQ;
                state == REQ:  state_nx = accept ? DROP : REQ;
                default:       state_nx = imem_resp_valid ? REQ : DROP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = fetch_pc;

    // fetch_pc has already stepped past the word now returning.
    assign din.pc    = FETCH_AW'(fetch_pc - ADDR_WIDTH'(INSTR_BYTES));
    assign din.instr = FETCH_DW'(imem_resp_data);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .count (fifo_count),
        .head  (head)
    );

    assign out_valid = (fifo_count != '0);
    assign out_pc    = ADDR_WIDTH'(head.pc);
    assign out_instr = DATA_WIDTH'(head.instr);

`ifdef FETCH_PERF_EN
    logic drop;

    assign drop = imem_resp_valid &&
                  ((state == DROP) || ((state == WAIT) && redirect_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_flush_cnt <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (redirect_valid && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (drop && (perf_drop_cnt != '1))
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            if (out_ready && !out_valid && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: sequential-stream reference model,
// bench-side instruction memory, directed scenarios then random traffic.
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;

    logic        req_valid2;
    logic [31:0] req_addr2;
    logic        req_ready2 = 1'b1;
    logic        resp_valid2 = 1'b0;
    logic [31:0] resp_data2 = '0;
    logic        out_valid2;
    logic [31:0] out_pc2;
    logic [31:0] out_instr2;
    logic        out_ready2 = 1'b1;

`ifdef FETCH_PERF_EN
    logic [31:0] pf1, pd1, ps1, pf2, pd2, ps2;
`endif

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    int acc_cnt = 0;
    int ready_mode = 0;
    int lat_min = 1;
    int lat_max = 1;

    exp_t        exp_q[$];
    exp_t        got2[$];
    logic [31:0] exp_req = '0;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_ready       (out_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_flush_cnt  (pf1),
        .perf_drop_cnt   (pd1),
        .perf_stall_cnt  (ps1)
`endif
    );

    fetch_queue #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (1'b0),
        .redirect_pc     (32'h0),
        .imem_req_valid  (req_valid2),
        .imem_req_addr   (req_addr2),
        .imem_req_ready  (req_ready2),
        .imem_resp_valid (resp_valid2),
        .imem_resp_data  (resp_data2),
        .out_valid       (out_valid2),
        .out_pc          (out_pc2),
        .out_instr       (out_instr2),
        .out_ready       (out_ready2)
`ifdef FETCH_PERF_EN
        ,
        .perf_flush_cnt  (pf2),
        .perf_drop_cnt   (pd2),
        .perf_stall_cnt  (ps2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The reference stream: after a restart, words come out sequentially.
    function automatic void restart(input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back({pc, pc ^ KEY});
        exp_req = pc;
    endfunction

    initial begin : memory
        bit          pend;
        int          wait_n;
        logic [31:0] paddr;
        pend = 0;
        wait_n = 0;
        paddr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                check("one_outstanding", 32'(pend), 32'd0);
                pend = 1;
                paddr = imem_req_addr;
                wait_n = $urandom_range(lat_max, lat_min);
                acc_cnt++;
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (pend) begin
                if (wait_n <= 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data = paddr ^ KEY;
                    pend = 0;
                end else begin
                    wait_n--;
                end
            end
            case (ready_mode)
                0:       imem_req_ready = 1'b1;
                1:       imem_req_ready = ($urandom_range(9, 0) < 7);
                default: imem_req_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        exp_t        e;
        logic        hold;
        logic [31:0] hold_addr;
        hold = 0;
        hold_addr = '0;
        restart(32'h0);
        forever begin
            @(negedge clk);
            if (rst) begin
                restart(32'h0);
                hold = 0;
            end else begin
                if (hold) begin
                    check("req_hold_valid", 32'(imem_req_valid), 32'd1);
                    check("req_hold_addr", imem_req_addr, hold_addr);
                end
                hold = imem_req_valid && !imem_req_ready && !redirect_valid;
                hold_addr = imem_req_addr;
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, exp_req);
                    exp_req = exp_req + 32'd4;
                end
                if (imem_resp_valid && !redirect_valid)
                    check("credit", 32'(dut.fifo_count < 3'(DEPTH)), 32'd1);
                if (redirect_valid) begin
                    restart(redirect_pc & ~32'd3);
                end else if (out_valid && out_ready) begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                    pops++;
                    exp_q.push_back({e.pc + 32'd4, (e.pc + 32'd4) ^ KEY});
                end
            end
        end
    end

    initial begin : wrap_mem
        logic        a2;
        logic [31:0] ad2;
        forever begin
            @(negedge clk);
            a2 = req_valid2 && req_ready2 && !rst;
            ad2 = req_addr2;
            if (rst)
                got2.delete();
            else if (out_valid2)
                got2.push_back({out_pc2, out_instr2});
            @(posedge clk);
            #1;
            resp_valid2 = a2;
            resp_data2 = ad2 ^ KEY;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_accepts(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < 60 && seen < n; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready)
                seen++;
        end
        check(name, 32'(seen), 32'(n));
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin : main
        int          a0;
        int          p0;
        int          n;
        logic [31:0] wexp;

        // Reset state, then back-to-back sequential fetch.
        ready_mode = 0;
        out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        rst = 1'b0;
        p0 = pops;
        tick();
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 50 && pops < p0 + 4; i++)
            tick();
        check("t1_four_outputs", 32'(pops >= p0 + 4), 32'd1);
        a0 = acc_cnt;
        repeat (20) tick();
        check("throughput", 32'(acc_cnt - a0), 32'd10);

        // Wrap from RESET_PC = FFFF_FFFC on the second instance.
        check("wrap_count", 32'(got2.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < got2.size(); i++) begin
            wexp = 32'hFFFF_FFFC + 32'(4 * i);
            check("wrap_pc", got2[i].pc, wexp);
            check("wrap_instr", got2[i].instr, wexp ^ KEY);
        end

        // Decode stalled: credit stops at DEPTH requests.
        out_ready = 1'b0;
        do_reset();
        a0 = acc_cnt;
        repeat (30) tick();
        check("full_accepts", 32'(acc_cnt - a0), 32'(DEPTH));
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_count", 32'(dut.fifo_count), 32'(DEPTH));
        check("full_head_pc", out_pc, 32'h0);
        check("full_head_instr", out_instr, KEY);
        out_ready = 1'b1;
        repeat (12) tick();

        // Redirect while waiting on a response.
        out_ready = 1'b0;
        lat_min = 1;
        lat_max = 1;
        do_reset();
        repeat (5) tick();
        lat_min = 3;
        lat_max = 3;
        wait_accepts("t3_accept", 1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        check("t3_flush_count", 32'(dut.fifo_count), 32'd0);
        check("t3_flush_valid", 32'(out_valid), 32'd0);
        check("t3_drop_req", 32'(imem_req_valid), 32'd0);
        n = 0;
        for (int i = 0; i < 30 && !(imem_req_valid && imem_req_ready); i++) begin
            @(negedge clk);
            n = i;
        end
        check("t3_req_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 30 && !out_valid; i++)
            tick();
        check("t3_out_pc", out_pc, 32'h100);
        check("t3_out_instr", out_instr, 32'h100 ^ KEY);
        out_ready = 1'b1;
        repeat (10) tick();

        // Memory back-pressure with a redirect on the third stalled cycle.
        lat_min = 1;
        lat_max = 1;
        ready_mode = 0;
        do_reset();
        wait_accepts("t4_accepts", 2);
        ready_mode = 2;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            wexp = (k < 3) ? 32'h8 : 32'h40;
            check("t4_req_valid", 32'(imem_req_valid), 32'd1);
            check("t4_req_addr", imem_req_addr, wexp);
            redirect_valid = (k == 2);
            redirect_pc = 32'h40;
            tick();
        end
        redirect_valid = 1'b0;
        ready_mode = 0;
        repeat (10) tick();

        // Redirect coincides with a response and a pop.
        out_ready = 1'b0;
        lat_min = 2;
        lat_max = 2;
        do_reset();
        wait_accepts("t5_accepts", 2);
        tick();
        tick();
        check("t5_head_present", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("t5_count", 32'(dut.fifo_count), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_req_valid", 32'(imem_req_valid), 32'd1);
        check("t5_req_addr", imem_req_addr, 32'h200);
        repeat (10) tick();

        // Random traffic with redirects and one mid-run reset.
        lat_min = 1;
        lat_max = 3;
        ready_mode = 1;
        do_reset();
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                redirect_valid = 1'b0;
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
            end
            out_ready = ($urandom_range(9, 0) < 6);
            redirect_valid = ($urandom_range(99, 0) < 3);
            redirect_pc = $urandom;
            if ($urandom_range(3, 0) == 0)
                redirect_pc = 32'hFFFF_FFF0 | (redirect_pc & 32'hF);
            tick();
        end
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        ready_mode = 0;
        repeat (40) tick();
        check("random_progress", 32'(pops - p0 > 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer side of the program-counter stream.
- Owns the fetch PC and issues sequential word requests to instruction memory over a valid/ready request channel. Memory answers on a valid-only response channel.
- Buffers returned {pc, instr} pairs in a small FIFO that feeds decode through a valid/ready handshake.
- A redirect (branch/jump) flushes the FIFO and discards any stale in-flight response.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch target; bits [1:0] ignored (forced 0)
- imem_req_valid  out  1  request present
- imem_req_addr  out  ADDR_WIDTH  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  response data valid (≥1 cycle after acceptance)
- imem_resp_data  in  DATA_WIDTH  instruction word
- out_valid  out  1  FIFO head valid
- out_pc  out  ADDR_WIDTH  PC of head entry
- out_instr  out  DATA_WIDTH  instruction of head entry
- out_ready  in  1  decode consumes head

Behaviour:
- Reset: fetch_pc = RESET_PC, FIFO empty, state IDLE.
  - Outputs after reset: imem_req_valid = 0, imem_req_addr = RESET_PC, out_valid = 0, out_pc = 0, out_instr = 0.
  - Reset mid-operation drops everything, including in-flight responses. Memory is reset with the block.
- At most one outstanding request.
- Credit rule: a request may be issued only when count + inflight < DEPTH, so a response always finds space.
- FSM states:
  - IDLE: enter REQ when credit is available. Assert imem_req_valid from the cycle after entry.
  - REQ: imem_req_valid = 1, imem_req_addr = fetch_pc.
    - Address is held stable until accepted.
    - On imem_req_valid & imem_req_ready: fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH), inflight = 1, go to WAIT.
  - WAIT: on imem_resp_valid, push {pc_of_request, data} and clear inflight.
    - Then go to REQ if credit remains, else IDLE.
  - DROP: in-flight response is stale. On imem_resp_valid, discard it, clear inflight, go to REQ.
- Redirect (highest priority in any state):
  - FIFO count goes to 0; a same-cycle pop or push is suppressed.
  - fetch_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - Next state depends on the current state:
    - From WAIT: go to DROP.
    - From DROP: stay in DROP.
    - From REQ, not accepted this cycle: request withdrawn; next cycle REQ with the new address. This is the only permitted valid drop.
    - From REQ, accepted this same cycle: go to DROP.
    - From IDLE: go to REQ.
  - First new request appears in the cycle after the redirect.
- Redirect in the same cycle as imem_resp_valid in WAIT: the response is discarded, inflight is cleared, and the next state is REQ (not DROP).
- FIFO:
  - out_valid = count ≠ 0. out_pc and out_instr are registered head contents.
  - Pop on out_valid & out_ready. Push and pop may occur in the same cycle; count is unchanged.
  - Full FIFO with a pending response cannot occur because of the credit rule. The bench asserts this.
- Back-to-back: with imem_req_ready held 1 and a 1-cycle response, throughput is one instruction per 2 cycles.

Optional Feature:
- FETCH_PERF_EN, when defined, adds three outputs:
  - perf_flush_cnt [31:0]: counts redirects.
  - perf_drop_cnt [31:0]: counts discarded responses.
  - perf_stall_cnt [31:0]: counts cycles with out_ready = 1 and out_valid = 0.
- All three counters are reset to 0 and saturate at all-ones.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - INSTR_BYTES = 4.
  - fetch_state_e enum {IDLE, REQ, WAIT, DROP}.
  - fetch_entry_t packed struct {pc, instr}, parameterised via package localparams matching the defaults.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with push, pop, flush, count, head.
  - Pointer width = $clog2(DEPTH), plus one extra bit for full/empty.

Test Plan:
- Reset, ready = 1, 1-cycle memory returning addr ^ 32'hA5A5_0000:
  - First request addr 0 in the cycle after reset release.
  - Outputs pc 0, 4, 8, 12 with matching data, in order.
- out_ready = 0, DEPTH = 4:
  - Exactly 4 requests are issued, then imem_req_valid stays 0.
  - count = 4, out_valid = 1, head pc 0.
- Redirect to 0x103 while in WAIT:
  - Next response is dropped; the FIFO empties immediately.
  - Next request addr 0x100; the first output afterwards is pc 0x100.
- imem_req_ready = 0 for 5 cycles:
  - imem_req_addr holds 0x8 throughout.
  - A redirect to 0x40 in cycle 3 changes the address to 0x40 on the next cycle with no acceptance.
- Redirect in the same cycle as a response and a pop:
  - Response discarded, FIFO count 0, next state REQ, address = redirect target.
- fetch_pc wrap: RESET_PC = 32'hFFFF_FFFC:
  - Outputs pc FFFF_FFFC, then 0, then 4.
